// File: rtl/fcims_ledger.sv
// Food-court ledger: per-item price/stock tables, running till total, shift-add line pricing.
// Optional FCIMS_LOW_STOCK_EN adds registered per-item low-stock flags (stock < LOW_THR).
module fcims_ledger #(
    parameter  int N_ITEMS = 4,
    parameter  int CNT_W   = 4,
    parameter  int PRICE_W = 4,
    parameter  int TOTAL_W = 8,
    parameter  int LOW_THR = 2,
    localparam int ITEM_W  = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1,
    localparam int LP_W    = PRICE_W + CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_op,
    input  logic [ITEM_W-1:0]  in_item,
    input  logic [CNT_W-1:0]   in_qty,
    input  logic [PRICE_W-1:0] in_price,
    input  logic               clear_total,
    output logic               resp_valid,
    output logic [1:0]         resp_status,
    output logic [LP_W-1:0]    line_price,
    output logic [TOTAL_W-1:0] total,
    input  logic [ITEM_W-1:0]  rd_item,
    output logic [CNT_W-1:0]   rd_stock,
    output logic [N_ITEMS-1:0] low_stock
);
    localparam int CW = $clog2(CNT_W) + 1;

    localparam logic [1:0] OP_RESTOCK = 2'b00, OP_SELL = 2'b01, OP_PRICE = 2'b10, OP_REFUND = 2'b11;
    localparam logic [1:0] ST_OK = 2'b00, ST_INS = 2'b01, ST_BAD = 2'b10, ST_SAT = 2'b11;

    typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;
    state_t state, next;

    logic [CNT_W-1:0]   stock [N_ITEMS];
    logic [PRICE_W-1:0] price [N_ITEMS];

    logic [1:0]         op_q;
    logic [ITEM_W-1:0]  item_q;
    logic               item_ok_q;
    logic [CNT_W-1:0]   qty_q;
    logic [PRICE_W-1:0] price_q;
    logic [LP_W-1:0]    acc, mcand;
    logic [CNT_W-1:0]   mq;
    logic [CW-1:0]      cnt;

    logic               in_ok;
    logic [ITEM_W-1:0]  in_idx, sidx;
    logic [CNT_W-1:0]   cur_stock, stock_add, new_stock;
    logic [CNT_W:0]     stock_sum;
    logic [TOTAL_W-1:0] lp_ext, new_total;
    logic [TOTAL_W:0]   tot_sum;
    logic               wr_stock, wr_total;
    logic [1:0]         st;

    assign in_ok    = 32'(in_item) < N_ITEMS;
    assign in_idx   = in_ok ? in_item : '0;
    assign sidx     = item_ok_q ? item_q : '0;
    assign in_ready = (state == IDLE);
    assign rd_stock = (32'(rd_item) < N_ITEMS) ? stock[rd_item] : '0;

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE: if (in_valid)
                      next = (!in_ok || in_op == OP_RESTOCK || in_op == OP_PRICE) ? RESP : MUL;
            MUL:  if (cnt == CW'(CNT_W - 1)) next = RESP;
            RESP: next = IDLE;
            default: next = IDLE;
        endcase
    end

    // Commit arithmetic for the latched transaction; applied only in RESP.
    always_comb begin
        cur_stock = stock[sidx];
        stock_sum = {1'b0, cur_stock} + {1'b0, qty_q};
        stock_add = stock_sum[CNT_W] ? '1 : stock_sum[CNT_W-1:0];
        lp_ext    = TOTAL_W'(acc);
        tot_sum   = {1'b0, total} + {1'b0, lp_ext};
        new_stock = cur_stock;
        new_total = total;
        wr_stock  = 1'b0;
        wr_total  = 1'b0;
        st        = ST_OK;
        if (!item_ok_q) begin
            st = ST_BAD;
        end else begin
            case (op_q)
                OP_RESTOCK: begin
                    new_stock = stock_add;
                    wr_stock  = 1'b1;
                    if (stock_sum[CNT_W]) st = ST_SAT;
                end
                OP_SELL: begin
                    if (cur_stock < qty_q) begin
                        st = ST_INS;
                    end else begin
                        new_stock = cur_stock - qty_q;
                        wr_stock  = 1'b1;
                        wr_total  = 1'b1;
                        new_total = tot_sum[TOTAL_W] ? '1 : tot_sum[TOTAL_W-1:0];
                        if (tot_sum[TOTAL_W]) st = ST_SAT;
                    end
                end
                OP_REFUND: begin
                    if (total < lp_ext) begin
                        st = ST_INS;
                    end else begin
                        new_total = total - lp_ext;
                        wr_total  = 1'b1;
                        new_stock = stock_add;
                        wr_stock  = 1'b1;
                        if (stock_sum[CNT_W]) st = ST_SAT;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < N_ITEMS; i++) begin
                stock[i] <= '0;
                price[i] <= '0;
            end
            total       <= '0;
            line_price  <= '0;
            resp_valid  <= 1'b0;
            resp_status <= ST_OK;
            op_q        <= '0;
            item_q      <= '0;
            item_ok_q   <= 1'b0;
            qty_q       <= '0;
            price_q     <= '0;
            acc         <= '0;
            mcand       <= '0;
            mq          <= '0;
            cnt         <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: if (in_valid) begin
                    op_q      <= in_op;
                    item_q    <= in_item;
                    item_ok_q <= in_ok;
                    qty_q     <= in_qty;
                    price_q   <= in_price;
                    acc       <= '0;
                    mcand     <= LP_W'(price[in_idx]);
                    mq        <= in_qty;
                    cnt       <= '0;
                end
                MUL: begin
                    if (mq[0]) acc <= acc + mcand;
                    mcand <= mcand << 1;
                    mq    <= mq >> 1;
                    cnt   <= cnt + CW'(1);
                end
                RESP: begin
                    resp_valid  <= 1'b1;
                    resp_status <= st;
                    if (wr_stock) stock[sidx] <= new_stock;
                    if (wr_total) total <= new_total;
                    if (item_ok_q && op_q == OP_PRICE) price[sidx] <= price_q;
                    if (item_ok_q && (op_q == OP_SELL || op_q == OP_REFUND)) line_price <= acc;
                end
                default: ;
            endcase
            // Clear wins over any same-edge commit to the total.
            if (clear_total) total <= '0;
        end
    end

`ifdef FCIMS_LOW_STOCK_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            low_stock <= '0;
        end else begin
            for (int i = 0; i < N_ITEMS; i++)
                low_stock[i] <= 32'(stock[i]) < LOW_THR;
        end
    end
`else
    assign low_stock = '0;
`endif

endmodule

// File: tb/tb_fcims_ledger.sv
// Randomized bench for fcims_ledger against a transaction-level model, plus directed literal checks.
module tb_fcims_ledger;
    localparam int NI = 3;   // 3 slots so that index 3 is a reachable bad item
    localparam int CW = 4;
    localparam int PW = 4;
    localparam int TW = 8;
    localparam int LT = 2;
    localparam int MAXS = (1 << CW) - 1;
    localparam int MAXT = (1 << TW) - 1;
`ifdef FCIMS_LOW_STOCK_EN
    localparam bit LOW_EN = 1'b1;
`else
    localparam bit LOW_EN = 1'b0;
`endif

    logic clk = 0;
    logic reset = 0;
    logic in_valid = 0;
    logic in_ready;
    logic [1:0] in_op = 0;
    logic [1:0] in_item = 0;
    logic [CW-1:0] in_qty = 0;
    logic [PW-1:0] in_price = 0;
    logic clear_total = 0;
    logic resp_valid;
    logic [1:0] resp_status;
    logic [PW+CW-1:0] line_price;
    logic [TW-1:0] total;
    logic [1:0] rd_item = 0;
    logic [CW-1:0] rd_stock;
    logic [NI-1:0] low_stock;

    fcims_ledger #(.N_ITEMS(NI), .CNT_W(CW), .PRICE_W(PW), .TOTAL_W(TW), .LOW_THR(LT)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_item(in_item), .in_qty(in_qty), .in_price(in_price),
        .clear_total(clear_total), .resp_valid(resp_valid), .resp_status(resp_status),
        .line_price(line_price), .total(total), .rd_item(rd_item), .rd_stock(rd_stock),
        .low_stock(low_stock)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: applies each accepted op at its due edge with plain arithmetic.
    int m_stock[NI], m_price[NI];
    int m_total = 0, m_lp = 0;
    bit m_busy = 0;
    int m_due = 0;
    int t_op, t_item, t_qty, t_price;
    bit e_valid = 0;
    int e_status = 0;
    bit [NI-1:0] e_low = '0;

    function automatic void commit();
        int s, t, lp;
        if (t_item >= NI) begin
            e_status = 2;
            return;
        end
        lp = m_price[t_item] * t_qty;
        case (t_op)
            0: begin
                s = m_stock[t_item] + t_qty;
                e_status = (s > MAXS) ? 3 : 0;
                m_stock[t_item] = (s > MAXS) ? MAXS : s;
            end
            2: begin
                m_price[t_item] = t_price;
                e_status = 0;
            end
            1: begin
                m_lp = lp;
                if (m_stock[t_item] < t_qty) e_status = 1;
                else begin
                    m_stock[t_item] -= t_qty;
                    t = m_total + lp;
                    e_status = (t > MAXT) ? 3 : 0;
                    m_total = (t > MAXT) ? MAXT : t;
                end
            end
            default: begin
                m_lp = lp;
                if (m_total < lp) e_status = 1;
                else begin
                    m_total -= lp;
                    s = m_stock[t_item] + t_qty;
                    e_status = (s > MAXS) ? 3 : 0;
                    m_stock[t_item] = (s > MAXS) ? MAXS : s;
                end
            end
        endcase
    endfunction

    always @(posedge clk) begin
        bit idle;
        bit [NI-1:0] low_nx;
        if (!reset) begin
            for (int i = 0; i < NI; i++) begin m_stock[i] = 0; m_price[i] = 0; end
            m_total = 0; m_lp = 0; m_busy = 0; e_valid = 0; e_status = 0; e_low = '0;
        end else begin
            for (int i = 0; i < NI; i++) low_nx[i] = LOW_EN && (m_stock[i] < LT);
            idle = !m_busy;
            e_valid = 0;
            if (m_busy) begin
                m_due--;
                if (m_due == 0) begin commit(); m_busy = 0; e_valid = 1; end
            end
            if (clear_total) m_total = 0;
            if (idle && in_valid) begin
                t_op = in_op; t_item = in_item; t_qty = in_qty; t_price = in_price;
                m_busy = 1;
                m_due = (t_item >= NI || t_op == 0 || t_op == 2) ? 1 : CW + 1;
            end
            e_low = low_nx;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", in_ready, !m_busy);
            chk("resp_valid", resp_valid, e_valid);
            if (e_valid) chk("resp_status", resp_status, e_status);
            chk("line_price", line_price, m_lp);
            chk("total", total, m_total);
            chk("rd_stock", rd_stock, (rd_item < NI) ? m_stock[rd_item] : 0);
            chk("low_stock", low_stock, e_low);
        end
    end

    // Issues one transaction; returns status and edges from accept to the response cycle.
    task automatic do_txn(input int op, input int item, input int qty, input int pr,
                          input int clr_edge, output int st, output int n);
        bit rdy, acc, got;
        @(negedge clk); #1;
        in_valid = 1; in_op = 2'(op); in_item = 2'(item); in_qty = CW'(qty); in_price = PW'(pr);
        acc = 0;
        for (int w = 0; w < 50; w++) begin
            rdy = in_ready;
            @(posedge clk);
            if (rdy) begin acc = 1; break; end
            #1;
        end
        #1;
        in_valid = 0;
        in_op = 2'($urandom); in_item = 2'($urandom); in_qty = CW'($urandom); in_price = PW'($urandom);
        if (!acc) chk("accept_timeout", 0, 1);
        n = 0; got = 0; st = -1;
        for (int g = 0; g < 40; g++) begin
            @(negedge clk);
            if (resp_valid) begin got = 1; st = resp_status; break; end
            #1 clear_total = (n + 1 == clr_edge);
            @(posedge clk);
            n++;
        end
        clear_total = 0;
        if (!got) chk("resp_timeout", 0, 1);
    endtask

    task automatic rd(input int item, output int v);
        #1 rd_item = 2'(item);
        #1 v = rd_stock;
    endtask

    initial begin
        int st, n, v;
        bit seen;
        repeat (3) @(posedge clk);
        #1 reset = 1;
        chk_en = 1;
        @(negedge clk);
        chk("rst_total", total, 0);
        chk("rst_lp", line_price, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_valid", resp_valid, 0);

        do_txn(2, 1, 0, 7, 0, st, n);  chk("price_st", st, 0); chk("price_lat", n, 1);
        do_txn(0, 1, 5, 0, 0, st, n);  chk("restock_st", st, 0); chk("restock_lat", n, 1);
        rd(1, v); chk("stock1_5", v, 5);
        do_txn(1, 1, 3, 0, 0, st, n);
        chk("sell_st", st, 0); chk("sell_lat", n, CW + 1);
        chk("sell_lp", line_price, 21); chk("sell_tot", total, 21);
        rd(1, v); chk("stock1_2", v, 2);
        do_txn(1, 1, 3, 0, 0, st, n);
        chk("ins_st", st, 1); chk("ins_tot", total, 21);
        rd(1, v); chk("ins_stock", v, 2);
        do_txn(3, 1, 1, 0, 0, st, n);
        chk("ref_st", st, 0); chk("ref_tot", total, 14); chk("ref_lp", line_price, 7);
        rd(1, v); chk("ref_stock", v, 3);

        do_txn(2, 2, 0, 15, 0, st, n);
        do_txn(0, 2, 15, 0, 0, st, n); chk("rs15_st", st, 0);
        @(negedge clk); #1 clear_total = 1;
        @(negedge clk); #1 clear_total = 0;
        do_txn(1, 2, 15, 0, 0, st, n);
        chk("big_st", st, 0); chk("big_tot", total, 225); chk("big_lp", line_price, 225);
        do_txn(0, 2, 15, 0, 0, st, n);
        do_txn(1, 2, 15, 0, 0, st, n);
        chk("ovf_st", st, 3); chk("ovf_tot", total, 255);
        rd(2, v); chk("ovf_stock", v, 0);
        do_txn(0, 0, 10, 0, 0, st, n); chk("rs10_st", st, 0);
        do_txn(0, 0, 10, 0, 0, st, n); chk("rsat_st", st, 3);
        rd(0, v); chk("rsat_stock", v, 15);
        do_txn(1, 3, 2, 0, 0, st, n);
        chk("bad_st", st, 2); chk("bad_lat", n, 1); chk("bad_lp", line_price, 225);

        do_txn(1, 1, 2, 0, CW + 1, st, n);
        chk("clr_st", st, 3); chk("clr_tot", total, 0); chk("clr_lp", line_price, 14);
        chk("low_pre", low_stock[1], 0);
        rd(1, v); chk("clr_stock", v, 1);
        @(negedge clk);
        chk("low_post", low_stock[1], LOW_EN);
        do_txn(1, 0, 0, 0, 0, st, n);
        chk("q0_st", st, 0); chk("q0_lp", line_price, 0); chk("q0_tot", total, 0);

        @(negedge clk); #1;
        in_valid = 1; in_op = 1; in_item = 1; in_qty = 1;
        @(posedge clk); #1 in_valid = 0;
        @(posedge clk); @(posedge clk); #1 reset = 0;
        @(posedge clk); #1 reset = 1;
        seen = 0;
        repeat (8) begin @(negedge clk); if (resp_valid) seen = 1; end
        chk("abort_noresp", seen, 0); chk("abort_tot", total, 0);
        rd(1, v); chk("abort_stock", v, 0);
        rd(0, v); chk("abort_stock0", v, 0);

        for (int c = 0; c < 4000; c++) begin
            @(negedge clk); #1;
            reset       = ($urandom_range(0, 399) != 0);
            in_valid    = $urandom_range(0, 2) != 0;
            in_op       = 2'($urandom);
            in_item     = 2'($urandom_range(0, NI));
            in_qty      = CW'($urandom);
            in_price    = PW'($urandom);
            clear_total = ($urandom_range(0, 23) == 0);
            rd_item     = 2'($urandom);
        end
        @(negedge clk); #1;
        reset = 1; in_valid = 0; clear_total = 0;
        repeat (CW + 4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
